// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide unit.
// Used by ex_muldiv (MULDIV_FAST_MUL_EN selects the single-cycle multiply path).
package muldiv_pkg;

   localparam int          XLEN_DEF      = 32;
   localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN       = 32'h8000_0000;

   typedef enum logic [2:0] {
      FN_MUL    = 3'd0,
      FN_MULH   = 3'd1,
      FN_MULHSU = 3'd2,
      FN_MULHU  = 3'd3,
      FN_DIV    = 3'd4,
      FN_DIVU   = 3'd5,
      FN_REM    = 3'd6,
      FN_REMU   = 3'd7
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_iter_core.sv
// One CALC step: ITER_BITS rounds of shift-add (multiply) or restoring
// shift-subtract (divide) on a {high, low} accumulator of unsigned magnitudes.
module muldiv_iter_core #(
   parameter int XLEN      = 32,
   parameter int ITER_BITS = 1
) (
   input  logic              is_div,
   input  logic [2*XLEN-1:0] acc,
   input  logic [XLEN-1:0]   opnd,
   output logic [2*XLEN-1:0] acc_next
);

   logic [2*XLEN-1:0] work;
   logic [XLEN:0]     sum;
   logic [XLEN:0]     shifted;
   logic [XLEN:0]     diff;

   // Divide: high half is the partial remainder, low half shifts dividend out / quotient in.
   // Multiply: low half holds the multiplier, high half accumulates with carry shifted down.
   always_comb begin
      work    = acc;
      sum     = {(XLEN+1){1'b0}};
      shifted = {(XLEN+1){1'b0}};
      diff    = {(XLEN+1){1'b0}};
      for (int i = 0; i < ITER_BITS; i++) begin
         if (is_div) begin
            shifted = work[2*XLEN-1:XLEN-1];
            diff    = shifted - {1'b0, opnd};
            if (!diff[XLEN]) begin
               work = {diff[XLEN-1:0], work[XLEN-2:0], 1'b1};
            end else begin
               work = {shifted[XLEN-1:0], work[XLEN-2:0], 1'b0};
            end
         end else begin
            sum  = {1'b0, work[2*XLEN-1:XLEN]} + (work[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
            work = {sum, work[XLEN-1:1]};
         end
      end
      acc_next = work;
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage RV32M multiply/divide unit: iterative FSM with pipeline stall and flush.
// Define MULDIV_FAST_MUL_EN for a single-cycle combinational multiply path.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int ITER_BITS = 1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_start,
   input  logic [2:0]      i_fun3,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic            i_flush,
   output logic            o_stall,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int            ITERS = XLEN / ITER_BITS;
   localparam int            CW    = $clog2(ITERS);
   localparam logic [CW-1:0] LAST  = CW'(ITERS - 1);

   state_t            state, next_state;
   funct3_t           fun3_q;
   logic [2*XLEN-1:0] acc, acc_next;
   logic [XLEN-1:0]   opnd;
   logic [CW-1:0]     count;
   logic              neg_main, neg_rem;
   logic [XLEN-1:0]   final_res, held_res;

   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic              div0, ovf, special;
   logic [XLEN-1:0]   special_res;
   logic              take;

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, calc_res;

`ifdef MULDIV_FAST_MUL_EN
   logic signed [XLEN:0]     fa, fb;
   logic signed [2*XLEN-1:0] fp;
   logic [XLEN-1:0]          fast_res;
`endif

   muldiv_iter_core #(.XLEN(XLEN), .ITER_BITS(ITER_BITS)) u_core (
      .is_div   (fun3_q[2]),
      .acc      (acc),
      .opnd     (opnd),
      .acc_next (acc_next)
   );

   // Operand decode at start: signedness, magnitudes and divide special cases.
   always_comb begin
      take     = i_start && !i_flush;
      a_signed = (i_fun3 == FN_MULH) || (i_fun3 == FN_MULHSU) ||
                 (i_fun3 == FN_DIV)  || (i_fun3 == FN_REM);
      b_signed = (i_fun3 == FN_MULH) || (i_fun3 == FN_DIV) || (i_fun3 == FN_REM);
      a_neg    = a_signed && i_rs1[XLEN-1];
      b_neg    = b_signed && i_rs2[XLEN-1];
      mag_a    = a_neg ? ({XLEN{1'b0}} - i_rs1) : i_rs1;
      mag_b    = b_neg ? ({XLEN{1'b0}} - i_rs2) : i_rs2;
      div0     = (i_rs2 == {XLEN{1'b0}});
      ovf      = !i_fun3[0] && (i_rs1 == INT_MIN) && (i_rs2 == {XLEN{1'b1}});
      special  = i_fun3[2] && (div0 || ovf);
      if (i_fun3[1]) begin
         special_res = div0 ? i_rs1 : {XLEN{1'b0}};
      end else begin
         special_res = div0 ? DIV_BY_ZERO_Q : INT_MIN;
      end
`ifdef MULDIV_FAST_MUL_EN
      fa       = {a_signed && i_rs1[XLEN-1], i_rs1};
      fb       = {b_signed && i_rs2[XLEN-1], i_rs2};
      fp       = fa * fb;
      fast_res = (i_fun3 == FN_MUL) ? fp[XLEN-1:0] : fp[2*XLEN-1:XLEN];
`endif
   end

   // Final sign correction of the last CALC step's accumulator.
   always_comb begin
      prod = neg_main ? ({(2*XLEN){1'b0}} - acc_next) : acc_next;
      quo  = neg_main ? ({XLEN{1'b0}} - acc_next[XLEN-1:0]) : acc_next[XLEN-1:0];
      rem  = neg_rem  ? ({XLEN{1'b0}} - acc_next[2*XLEN-1:XLEN]) : acc_next[2*XLEN-1:XLEN];
      case (fun3_q)
         FN_MUL:                       calc_res = prod[XLEN-1:0];
         FN_MULH, FN_MULHSU, FN_MULHU: calc_res = prod[2*XLEN-1:XLEN];
         FN_DIV, FN_DIVU:              calc_res = quo;
         default:                      calc_res = rem;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; DONE always returns to IDLE so an op is never restarted.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (take) begin
               if (special) begin
                  next_state = DONE;
`ifdef MULDIV_FAST_MUL_EN
               end else if (!i_fun3[2]) begin
                  next_state = DONE;
`endif
               end else begin
                  next_state = CALC;
               end
            end else begin
               next_state = IDLE;
            end
         end
         CALC: begin
            if (i_flush) begin
               next_state = IDLE;
            end else if (count == LAST) begin
               next_state = DONE;
            end else begin
               next_state = CALC;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath registers: latch at start, iterate in CALC, retire result in DONE.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         fun3_q    <= FN_MUL;
         acc       <= {(2*XLEN){1'b0}};
         opnd      <= {XLEN{1'b0}};
         count     <= {CW{1'b0}};
         neg_main  <= 1'b0;
         neg_rem   <= 1'b0;
         final_res <= {XLEN{1'b0}};
         held_res  <= {XLEN{1'b0}};
      end else begin
         if (state == IDLE && take) begin
            fun3_q   <= funct3_t'(i_fun3);
            acc      <= {{XLEN{1'b0}}, mag_a};
            opnd     <= mag_b;
            count    <= {CW{1'b0}};
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            if (special) begin
               final_res <= special_res;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!i_fun3[2]) begin
               final_res <= fast_res;
`endif
            end else begin
               final_res <= final_res;
            end
         end else if (state == CALC && !i_flush) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (count == LAST) begin
               final_res <= calc_res;
            end else begin
               final_res <= final_res;
            end
         end else if (state == DONE && !i_flush) begin
            held_res <= final_res;
         end else begin
            acc <= acc;
         end
      end
   end

   // Outputs: stall while accepting or iterating; flush suppresses completion.
   always_comb begin
      o_stall  = ((state == IDLE) && take) || (state == CALC);
      o_done   = (state == DONE) && !i_flush;
      o_result = o_done ? final_res : held_res;
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M vectors, random ops against
// an arithmetic reference model, flush, mid-op reset and back-to-back issue.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        flush;
   logic [2:0]  fun3;
   logic [31:0] rs1, rs2;
   logic        stall, done;
   logic [31:0] result;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int done_pulses = 0;
   logic [31:0] last_exp = 32'd0;

   ex_muldiv dut (
      .i_clk    (clk),
      .i_reset  (rst_n),
      .i_start  (start),
      .i_fun3   (fun3),
      .i_rs1    (rs1),
      .i_rs2    (rs2),
      .i_flush  (flush),
      .o_stall  (stall),
      .o_done   (done),
      .o_result (result)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done === 1'b1) done_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      int              ia, ib;
      logic [31:0]     r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = $signed(a);
      ib = $signed(b);
      r  = 32'd0;
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 32'd0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = ia / ib;
         end
         3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = ia % ib;
         end
         default: r = (b == 32'd0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!f[2]) return 1;
`endif
      return 33;
   endfunction

   // Issue one op with i_start held (EX frozen), scrambling operands after acceptance.
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int stalls,
                         output logic stall_in_done, output logic extra_done, output logic [31:0] held);
      fun3 = f; rs1 = a; rs2 = b; start = 1'b1;
      lat = 0; stalls = 0; res = 32'd0; stall_in_done = 1'b1;
      #1;
      if (stall === 1'b1) stalls++;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         rs1 = $urandom; rs2 = $urandom;
         #1;
         if (done === 1'b1) begin
            lat = k; res = result; stall_in_done = stall;
            break;
         end
         if (stall === 1'b1) stalls++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      #1;
      extra_done = done;
      held = result;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; fun3 = 3'd0; rs1 = 32'd0; rs2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (result !== 32'd0) $display("FAIL reset_result got %h want 0", result); else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++; if (done !== 1'b0 || stall !== 1'b0) $display("FAIL post_reset_idle got done=%b stall=%b want 0/0", done, stall); else pass_cnt++;
   endtask

   typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; } vec_t;
   vec_t vecs [12] = '{
      '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF},
      '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
      '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
      '{3'd5, 32'd100,       32'd7,         32'd14},
      '{3'd7, 32'd100,       32'd7,         32'd2},
      '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF},
      '{3'd7, 32'd5,         32'd0,         32'd5},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000}
   };

   task automatic test_directed();
      logic [31:0] r, held; int lat, stalls, el; logic sd, ed;
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat, stalls, sd, ed, held);
         el = exp_lat(vecs[i].f, vecs[i].a, vecs[i].b);
         total_cnt++; if (r !== vecs[i].e) $display("FAIL dir%0d_result got %h want %h", i, r, vecs[i].e); else pass_cnt++;
         total_cnt++; if (lat !== el) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, el); else pass_cnt++;
         total_cnt++; if (stalls !== el) $display("FAIL dir%0d_stall_cycles got %0d want %0d", i, stalls, el); else pass_cnt++;
         total_cnt++; if (sd !== 1'b0) $display("FAIL dir%0d_stall_in_done got %b want 0", i, sd); else pass_cnt++;
         total_cnt++; if (ed !== 1'b0) $display("FAIL dir%0d_done_pulse got %b want 0 after pulse", i, ed); else pass_cnt++;
         total_cnt++; if (held !== vecs[i].e) $display("FAIL dir%0d_held got %h want %h", i, held, vecs[i].e); else pass_cnt++;
         last_exp = vecs[i].e;
      end
   endtask

   task automatic test_random();
      logic [31:0] a, b, r, held, e; logic [2:0] f; int lat, stalls, el; logic sd, ed;
      logic [31:0] corner [4] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000};
      for (int i = 0; i < 30; i++) begin
         f = 3'($urandom_range(0, 7));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : $urandom;
         e  = ref_model(f, a, b);
         el = exp_lat(f, a, b);
         run_op(f, a, b, r, lat, stalls, sd, ed, held);
         total_cnt++; if (r !== e) $display("FAIL rnd%0d_result f=%0d a=%h b=%h got %h want %h", i, f, a, b, r, e); else pass_cnt++;
         total_cnt++; if (lat !== el) $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, el); else pass_cnt++;
         total_cnt++; if (stalls !== el) $display("FAIL rnd%0d_stall_cycles got %0d want %0d", i, stalls, el); else pass_cnt++;
         total_cnt++; if (ed !== 1'b0 || sd !== 1'b0) $display("FAIL rnd%0d_pulse got extra=%b stall=%b want 0/0", i, ed, sd); else pass_cnt++;
         last_exp = e;
      end
   endtask

   task automatic test_flush();
      logic [31:0] r, held, a, b; int lat, stalls, p0, el; logic sd, ed;
      // Flush on the 10th CALC cycle.
      fun3 = 3'd5; rs1 = 32'hFFFF_FFFF; rs2 = 32'd3; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin @(posedge clk); #1; end
      flush = 1'b1; #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL flush_calc_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (result !== last_exp) $display("FAIL flush_calc_result got %h want %h", result, last_exp); else pass_cnt++;
      @(posedge clk); #1; flush = 1'b0; start = 1'b0; #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL flush_calc_idle got stall=%b want 0", stall); else pass_cnt++;
      p0 = done_pulses;
      repeat (40) @(posedge clk);
      #1;
      total_cnt++; if (done_pulses !== p0) $display("FAIL flush_calc_no_done got %0d pulses want 0", done_pulses - p0); else pass_cnt++;
      run_op(3'd5, 32'd9, 32'd3, r, lat, stalls, sd, ed, held);
      total_cnt++; if (r !== 32'd3) $display("FAIL divu_after_flush got %h want 3", r); else pass_cnt++;
      total_cnt++; if (lat !== 33) $display("FAIL divu_after_flush_latency got %0d want 33", lat); else pass_cnt++;
      last_exp = 32'd3;
      // Flush in the DONE cycle.
      a = $urandom; b = $urandom; el = exp_lat(3'd3, a, b);
      fun3 = 3'd3; rs1 = a; rs2 = b; start = 1'b1;
      for (int k = 1; k <= el; k++) begin @(posedge clk); #1; end
      flush = 1'b1; #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL flush_done_suppress got %b want 0", done); else pass_cnt++;
      total_cnt++; if (result !== last_exp) $display("FAIL flush_done_result got %h want %h", result, last_exp); else pass_cnt++;
      @(posedge clk); #1; flush = 1'b0; start = 1'b0; #1;
      total_cnt++; if (stall !== 1'b0 || done !== 1'b0) $display("FAIL flush_done_idle got stall=%b done=%b want 0/0", stall, done); else pass_cnt++;
      total_cnt++; if (result !== last_exp) $display("FAIL flush_done_held got %h want %h", result, last_exp); else pass_cnt++;
      // Flush together with start in IDLE: no start.
      fun3 = 3'd4; rs1 = 32'd100; rs2 = 32'd7; start = 1'b1; flush = 1'b1; #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL flush_start_stall got %b want 0", stall); else pass_cnt++;
      @(posedge clk); #1; flush = 1'b0; start = 1'b0; #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL flush_start_not_started got stall=%b want 0", stall); else pass_cnt++;
      p0 = done_pulses;
      repeat (40) @(posedge clk);
      #1;
      total_cnt++; if (done_pulses !== p0) $display("FAIL flush_start_no_done got %0d pulses want 0", done_pulses - p0); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int p0;
      fun3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin @(posedge clk); #1; end
      rst_n = 1'b0; start = 1'b0; #1;
      total_cnt++; if (stall !== 1'b0) $display("FAIL midreset_stall got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL midreset_done got %b want 0", done); else pass_cnt++;
      total_cnt++; if (result !== 32'd0) $display("FAIL midreset_result got %h want 0", result); else pass_cnt++;
      @(posedge clk); #1; rst_n = 1'b1;
      p0 = done_pulses;
      repeat (40) @(posedge clk);
      #1;
      total_cnt++; if (done_pulses !== p0 || stall !== 1'b0) $display("FAIL midreset_idle got pulses=%0d stall=%b want 0/0", done_pulses - p0, stall); else pass_cnt++;
      last_exp = 32'd0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] a1, b1, a2, b2, e1, e2, r1, r2, h1, h2; int l1, l2, s1, s2, p0; logic d1, d2, x1, x2;
      a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom_range(1, 1000);
      e1 = ref_model(3'd0, a1, b1);
      e2 = ref_model(3'd4, a2, b2);
      p0 = done_pulses;
      run_op(3'd0, a1, b1, r1, l1, s1, d1, x1, h1);
      run_op(3'd4, a2, b2, r2, l2, s2, d2, x2, h2);
      total_cnt++; if (r1 !== e1) $display("FAIL b2b_mul got %h want %h", r1, e1); else pass_cnt++;
      total_cnt++; if (r2 !== e2) $display("FAIL b2b_div got %h want %h", r2, e2); else pass_cnt++;
      total_cnt++; if (l2 !== exp_lat(3'd4, a2, b2)) $display("FAIL b2b_div_latency got %0d want %0d", l2, exp_lat(3'd4, a2, b2)); else pass_cnt++;
      total_cnt++; if (done_pulses - p0 !== 2) $display("FAIL b2b_pulses got %0d want 2", done_pulses - p0); else pass_cnt++;
      total_cnt++; if (h2 !== e2) $display("FAIL b2b_held got %h want %h", h2, e2); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
